// File: rtl/audio_udp_pack.sv
// Packs WM8978 stereo samples into fixed-size UDP payloads through a ping-pong buffer,
// handing each full bank to the UDP sender with a start/req/done handshake.
module audio_udp_pack #(
    parameter int PKT_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [31:0] adc_data,
    input  logic        pkt_en,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    input  logic        tx_done,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  rx_sync_q, rx_sync_d;
    logic        pkt_en_q, pkt_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic        wr_bank_q, wr_bank_d;
    logic [1:0]  full_q, full_d;
    logic        rd_bank_q, rd_bank_d;
    logic [AW:0] rd_addr_q, rd_addr_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        wr_stb;
    logic        wr_en;
    logic [31:0] mem [2*PKT_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_sync_q <= '0;
            pkt_en_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rx_sync_q <= rx_sync_d;
            pkt_en_q  <= pkt_en_d;
            wr_addr_q <= wr_addr_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank_q, wr_addr_q}] <= adc_data;
    end

    // Two sync stages then an edge register; wr_stb is the rising edge of the synchronised strobe.
    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], rx_done};
        pkt_en_d  = pkt_en;
        wr_stb    = rx_sync_q[1] & ~rx_sync_q[2];
        wr_en     = wr_stb & pkt_en & ~full_q[wr_bank_q];
        ovf       = wr_stb & pkt_en & full_q[wr_bank_q];
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (wr_en) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (&wr_addr_q) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end else if (pkt_en_q && !pkt_en) begin
            wr_addr_d = '0;
        end
        if (state_q == DONE)
            full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (full_q[rd_bank_q] && pkt_en) state_d = START;
            START: state_d = SEND;
            SEND:  if (tx_done) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    // rd_addr saturates at PKT_WORDS so surplus requests leave tx_data untouched.
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        tx_data_d = tx_data_q;
        if (state_q == START)
            rd_addr_d = '0;
        if (state_q == SEND && tx_req && !rd_addr_q[AW]) begin
            tx_data_d = mem[{rd_bank_q, rd_addr_q[AW-1:0]}];
            rd_addr_d = rd_addr_q + 1'b1;
        end
        if (state_q == DONE)
            rd_bank_d = ~rd_bank_q;
    end

    always_comb begin
        tx_start_en = (state_q == START);
        tx_data     = tx_data_q;
        tx_byte_num = 16'(PKT_WORDS * 4);
    end

endmodule

// File: tb/tb_audio_udp_pack.sv
// Self-checking bench for audio_udp_pack with a 4-word packet; a queue-based packet
// model predicts payloads and dropped samples.
module tb_audio_udp_pack;

    localparam int PW  = 4;
    localparam int AWL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [31:0] adc_data;
    logic        pkt_en;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        ovf;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int ovf_cnt = 0;
    int last_start_cyc = 0;
    int exp_ovf = 0;
    bit sender_done;

    logic [31:0] fill_q[$];
    logic [31:0] pkt_q[$];
    int          pending;
    logic [31:0] rd_words [PW];

    always #5 clk = ~clk;

    audio_udp_pack #(.PKT_WORDS(PW), .AW(AWL)) dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .adc_data(adc_data),
        .pkt_en(pkt_en), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done), .ovf(ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start_en === 1'b1) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc;
        end
        if (ovf === 1'b1)
            ovf_cnt <= ovf_cnt + 1;
    end

    // Packet-level model: two packet slots; a sample is kept, dropped silently or dropped with ovf.
    function automatic void model_reset();
        fill_q.delete();
        pkt_q.delete();
        pending = 0;
    endfunction

    function automatic bit model_sample(input logic [31:0] d);
        if (pkt_en !== 1'b1) return 1'b0;
        if (pending == 2) return 1'b1;
        fill_q.push_back(d);
        if (fill_q.size() == PW) begin
            foreach (fill_q[i]) pkt_q.push_back(fill_q[i]);
            fill_q.delete();
            pending++;
        end
        return 1'b0;
    endfunction

    function automatic void model_done();
        if (pending > 0) pending--;
    endfunction

    function automatic logic [31:0] model_next_word();
        if (pkt_q.size() > 0) return pkt_q.pop_front();
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; rx_done = 1'b0; adc_data = '0; pkt_en = 1'b0;
        tx_req = 1'b0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_sample(input logic [31:0] d);
        @(posedge clk);
        #($urandom_range(9, 1));
        adc_data = d;
        rx_done  = 1'b1;
        exp_ovf += int'(model_sample(d));
        #30 rx_done = 1'b0;
        #($urandom_range(90, 60));
    endtask

    task automatic wait_start(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (start_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (start_cnt >= target) ok = 1'b1;
    endtask

    task automatic udp_read(input bit b2b);
        if (b2b) begin
            @(posedge clk);
            #1 tx_req = 1'b1;
            for (int i = 0; i < PW; i++) begin
                @(posedge clk);
                #1 rd_words[i] = tx_data;
                if (i == PW - 1) tx_req = 1'b0;
            end
        end else begin
            for (int i = 0; i < PW; i++) begin
                @(posedge clk);
                #1 tx_req = 1'b1;
                @(posedge clk);
                #1 tx_req = 1'b0;
                rd_words[i] = tx_data;
                @(posedge clk);
            end
        end
    endtask

    task automatic pulse_done(output int c);
        @(posedge clk);
        #1 tx_done = 1'b1;
        c = cyc;
        @(posedge clk);
        #1 tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_start_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b expected 0", tx_start_en); end
        n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", tx_data); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        n_cmp++; if (tx_byte_num !== 16'(PW * 4)) begin n_fail++; $display("[TB] FAIL reset_bytes: got %0d expected %0d", tx_byte_num, PW * 4); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_start_en !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_start: got %b expected 0", tx_start_en); end
        n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("[TB] FAIL post_reset_data: got %h expected 0", tx_data); end
    endtask

    task automatic test_single_packet();
        int s0, o0, e0, dc;
        bit ok;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b1;
        s0 = start_cnt; o0 = ovf_cnt; e0 = exp_ovf;
        send_sample(32'h1111_1111);
        send_sample(32'h2222_2222);
        send_sample(32'h3333_3333);
        send_sample(32'h4444_4444);
        wait_start(s0 + 1, 100, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start: got %b expected 1", ok); end
        n_cmp++; if (tx_byte_num !== 16'd16) begin n_fail++; $display("[TB] FAIL single_bytes: got %0d expected 16", tx_byte_num); end
        udp_read(1'b0);
        for (int i = 0; i < PW; i++) begin
            exp = model_next_word();
            n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL single_word%0d: got %h expected %h", i, rd_words[i], exp); end
        end
        pulse_done(dc);
        model_done();
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (start_cnt - s0 !== 1) begin n_fail++; $display("[TB] FAIL single_start_count: got %0d expected 1", start_cnt - s0); end
        n_cmp++; if (ovf_cnt - o0 !== exp_ovf - e0) begin n_fail++; $display("[TB] FAIL single_ovf: got %0d expected %0d", ovf_cnt - o0, exp_ovf - e0); end
    endtask

    task automatic test_ping_pong();
        int s0, o0, e0, dc, dc2;
        bit ok1, ok2;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b1;
        sender_done = 1'b0;
        s0 = start_cnt; o0 = ovf_cnt; e0 = exp_ovf;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_sample(32'(i));
                sender_done = 1'b1;
            end
            begin
                wait_start(s0 + 1, 300, ok1);
                n_cmp++; if (ok1 !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_start1: got %b expected 1", ok1); end
                udp_read(1'b1);
                for (int i = 0; i < PW; i++) begin
                    exp = model_next_word();
                    n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL pp_pkt1_word%0d: got %h expected %h", i, rd_words[i], exp); end
                end
                for (int i = 0; i < 2000 && !sender_done; i++) @(posedge clk);
                n_cmp++; if (sender_done !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_sender_timeout: got %b expected 1", sender_done); end
                repeat (50) @(posedge clk);
                pulse_done(dc);
                model_done();
                wait_start(s0 + 2, 20, ok2);
                n_cmp++; if (ok2 !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_start2: got %b expected 1", ok2); end
                n_cmp++; if (last_start_cyc - dc !== 3) begin n_fail++; $display("[TB] FAIL pp_turnaround: got %0d cycles expected 3", last_start_cyc - dc); end
                udp_read(1'b1);
                for (int i = 0; i < PW; i++) begin
                    exp = model_next_word();
                    n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL pp_pkt2_word%0d: got %h expected %h", i, rd_words[i], exp); end
                end
                pulse_done(dc2);
                model_done();
            end
        join
        n_cmp++; if (ovf_cnt - o0 !== exp_ovf - e0) begin n_fail++; $display("[TB] FAIL pp_ovf: got %0d expected %0d", ovf_cnt - o0, exp_ovf - e0); end
    endtask

    task automatic test_overflow();
        int s0, o0, e0, dc;
        bit ok;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b1;
        s0 = start_cnt; o0 = ovf_cnt; e0 = exp_ovf;
        for (int i = 0; i < 10; i++) send_sample($urandom);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (ovf_cnt - o0 !== exp_ovf - e0) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d expected %0d", ovf_cnt - o0, exp_ovf - e0); end
        for (int p = 1; p <= 3; p++) begin
            if (p == 3) for (int i = 0; i < PW; i++) send_sample($urandom);
            wait_start(s0 + p, 200, ok);
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_start%0d: got %b expected 1", p, ok); end
            udp_read(1'b0);
            for (int i = 0; i < PW; i++) begin
                exp = model_next_word();
                n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL ovf_pkt%0d_word%0d: got %h expected %h", p, i, rd_words[i], exp); end
            end
            pulse_done(dc);
            model_done();
        end
    endtask

    task automatic test_enable_gating();
        int s0, o0, e0, dc;
        bit ok;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b0;
        s0 = start_cnt; o0 = ovf_cnt; e0 = exp_ovf;
        for (int i = 0; i < 6; i++) send_sample($urandom);
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (start_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL gate_start: got %0d expected 0", start_cnt - s0); end
        n_cmp++; if (ovf_cnt - o0 !== exp_ovf - e0) begin n_fail++; $display("[TB] FAIL gate_ovf: got %0d expected %0d", ovf_cnt - o0, exp_ovf - e0); end
        @(posedge clk);
        #1 pkt_en = 1'b1;
        send_sample($urandom);
        send_sample($urandom);
        @(posedge clk);
        #1 pkt_en = 1'b0;
        fill_q.delete();
        repeat (3) @(posedge clk);
        #1 pkt_en = 1'b1;
        for (int i = 0; i < PW; i++) send_sample($urandom);
        wait_start(s0 + 1, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL gate_restart: got %b expected 1", ok); end
        udp_read(1'b1);
        for (int i = 0; i < PW; i++) begin
            exp = model_next_word();
            n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL gate_word%0d: got %h expected %h", i, rd_words[i], exp); end
        end
        pulse_done(dc);
        model_done();
    endtask

    task automatic test_async_strobe();
        int s0, o0, e0, dc, got_pkts;
        bit ok;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b1;
        s0 = start_cnt; o0 = ovf_cnt; e0 = exp_ovf;
        got_pkts = 0;
        fork
            for (int i = 0; i < 1000; i++) send_sample($urandom);
            begin
                for (int p = 0; p < 1000 / PW; p++) begin
                    wait_start(s0 + p + 1, 400, ok);
                    if (!ok) break;
                    udp_read(1'b1);
                    for (int i = 0; i < PW; i++) begin
                        exp = model_next_word();
                        n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL async_pkt%0d_word%0d: got %h expected %h", p, i, rd_words[i], exp); end
                    end
                    pulse_done(dc);
                    model_done();
                    got_pkts++;
                end
            end
        join
        n_cmp++; if (got_pkts !== 1000 / PW) begin n_fail++; $display("[TB] FAIL async_packets: got %0d expected %0d", got_pkts, 1000 / PW); end
        n_cmp++; if (ovf_cnt - o0 !== exp_ovf - e0) begin n_fail++; $display("[TB] FAIL async_ovf: got %0d expected %0d", ovf_cnt - o0, exp_ovf - e0); end
    endtask

    task automatic test_reset_mid_send();
        int s0, s1, dc;
        bit ok;
        logic [31:0] exp;
        do_reset();
        pkt_en = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < PW; i++) send_sample($urandom);
        wait_start(s0 + 1, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_first_start: got %b expected 1", ok); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 tx_req = 1'b1;
            @(posedge clk);
            #1 tx_req = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_start_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_start: got %b expected 0", tx_start_en); end
        n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_data: got %h expected 0", tx_data); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_ovf: got %b expected 0", ovf); end
        n_cmp++; if (tx_byte_num !== 16'(PW * 4)) begin n_fail++; $display("[TB] FAIL rst_mid_bytes: got %0d expected %0d", tx_byte_num, PW * 4); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        s1 = start_cnt;
        repeat (2) @(posedge clk);
        pulse_done(dc);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (start_cnt - s1 !== 0) begin n_fail++; $display("[TB] FAIL rst_late_done: got %0d starts expected 0", start_cnt - s1); end
        for (int i = 0; i < PW; i++) send_sample($urandom);
        wait_start(s1 + 1, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_fresh_start: got %b expected 1", ok); end
        udp_read(1'b0);
        for (int i = 0; i < PW; i++) begin
            exp = model_next_word();
            n_cmp++; if (rd_words[i] !== exp) begin n_fail++; $display("[TB] FAIL rst_fresh_word%0d: got %h expected %h", i, rd_words[i], exp); end
        end
        pulse_done(dc);
        model_done();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_ping_pong();
        test_overflow();
        test_enable_gating();
        test_async_strobe();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
